// File: rtl/vga_timing_gen_if.sv
//------------------------------------------------------------------------------
// Module   : vga_timing_gen_if
// Brief    : Raster timing bundle from the VGA timing generator to colour/pins.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright,
               line_tick, frame_tick, frame_count
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright,
               line_tick, frame_tick, frame_count
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// Module   : vga_timing_gen
// Brief    : 640x480@60 raster timing: pixel strobe, h/v counters, sync, bright.
//            Define VGA_FRAME_COUNT_EN to build the 16-bit frame counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 514
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_timing_gen_if.master vga
);

    localparam int              c_DIV_W    = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [9:0]      c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      c_H_SYNC   = 10'(H_SYNC);
    localparam logic [9:0]      c_V_SYNC   = 10'(V_SYNC);
    localparam logic [9:0]      c_H_VS     = 10'(H_VIS_START);
    localparam logic [9:0]      c_H_VE     = 10'(H_VIS_END);
    localparam logic [9:0]      c_V_VS     = 10'(V_VIS_START);
    localparam logic [9:0]      c_V_VE     = 10'(V_VIS_END);

    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_h_count;
    logic [9:0]         r_v_count;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_bright;
    logic               r_line_tick;
    logic               r_frame_tick;

    logic               w_pix_en;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_frame_wrap;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;

    assign w_pix_en     = (r_div == c_DIV_LAST);
    assign w_h_wrap     = (r_h_count == c_H_LAST);
    assign w_v_wrap     = (r_v_count == c_V_LAST);
    assign w_frame_wrap = w_pix_en & w_h_wrap & w_v_wrap;

    always_comb begin
        w_h_next = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
        w_v_next = r_v_count;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 10'd0 : r_v_count + 10'd1;
        end
    end

    // Sync and bright are decoded from the next counts so that they always
    // line up with the hCount/vCount registers they are presented beside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_h_count    <= '0;
            r_v_count    <= '0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_bright     <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_div        <= r_div + c_DIV_ONE;
            r_line_tick  <= w_pix_en & w_h_wrap;
            r_frame_tick <= w_frame_wrap;
            if (w_pix_en) begin
                r_h_count <= w_h_next;
                r_v_count <= w_v_next;
                r_hsync   <= (w_h_next >= c_H_SYNC);
                r_vsync   <= (w_v_next >= c_V_SYNC);
                r_bright  <= (w_h_next >= c_H_VS) && (w_h_next <= c_H_VE) &&
                             (w_v_next >= c_V_VS) && (w_v_next <= c_V_VE);
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign vga.frame_count = r_frame_count;
`else
    assign vga.frame_count = 16'd0;
`endif

    assign vga.pix_en     = w_pix_en;
    assign vga.hCount     = r_h_count;
    assign vga.vCount     = r_v_count;
    assign vga.hSync      = r_hsync;
    assign vga.vSync      = r_vsync;
    assign vga.bright     = r_bright;
    assign vga.line_tick  = r_line_tick;
    assign vga.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench: default-timing DUT plus a shrunken-raster DUT.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

    typedef struct packed {
        logic        pe;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        lt;
        logic        ft;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n   = 0;
    int   tests = 0;
    int   fails = 0;

    obs_t q_a[$];
    obs_t q_b[$];

    vga_timing_gen_if vga_a ();
    vga_timing_gen_if vga_b ();

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst),
        .vga (vga_a.master)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(16),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .vga (vga_b.master)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the reference model is a pure function of it.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic obs_t model(input int cnt, input int dv, input int ht, input int hs,
                                   input int hvs, input int hve, input int vt, input int vs,
                                   input int vvs, input int vve);
        obs_t m;
        int pix = cnt / dv;
        int d   = cnt % dv;
        int h   = pix % ht;
        int v   = (pix / ht) % vt;
        m.pe = (d == dv - 1);
        m.h  = 10'(h);
        m.v  = 10'(v);
        m.hs = (h >= hs);
        m.vs = (v >= vs);
        m.br = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
        m.lt = (d == 0) && (pix > 0) && (h == 0);
        m.ft = m.lt && (v == 0);
`ifdef VGA_FRAME_COUNT_EN
        m.fc = 16'((pix / (ht * vt)) % 65536);
`else
        m.fc = 16'd0;
`endif
        return m;
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o = {vga_a.pix_en, vga_a.hCount, vga_a.vCount, vga_a.hSync, vga_a.vSync,
             vga_a.bright, vga_a.line_tick, vga_a.frame_tick, vga_a.frame_count};
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o = {vga_b.pix_en, vga_b.hCount, vga_b.vCount, vga_b.hSync, vga_b.vSync,
             vga_b.bright, vga_b.line_tick, vga_b.frame_tick, vga_b.frame_count};
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s n=%0d: got pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b lt=%0b ft=%0b fc=%0d, expected pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b lt=%0b ft=%0b fc=%0d",
                     name, n, act.pe, act.h, act.v, act.hs, act.vs, act.br, act.lt, act.ft, act.fc,
                     exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.lt, exp.ft, exp.fc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s n=%0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    // Scoreboard: expectation queued just after each edge, compared mid-cycle.
    always @(posedge clk) begin
        #1;
        q_a.push_back(model(n, 4, 800, 96, 144, 783, 525, 2, 35, 514));
        q_b.push_back(model(n, 2, 20, 3, 5, 16, 10, 2, 3, 8));
    end

    always @(negedge clk) begin
        if (q_a.size() > 0) check_obs("sb_default", get_a(), q_a.pop_front());
        if (q_b.size() > 0) check_obs("sb_small", get_b(), q_b.pop_front());
    end

    function automatic vec_t mk(input int cnt, input logic pe, input int h, input int v,
                                input logic hs, input logic vs, input logic br, input logic lt);
        vec_t e;
        e.n   = cnt;
        e.exp = {pe, 10'(h), 10'(v), hs, vs, br, lt, 1'b0, 16'd0};
        return e;
    endfunction

    vec_t tbl[11];

    initial begin
        bit found;

        //            n     pe    h    v  hs   vs   br   lt
        tbl[0]  = mk(0,    1'b0, 0,   0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(3,    1'b1, 0,   0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(4,    1'b0, 1,   0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(380,  1'b0, 95,  0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(384,  1'b0, 96,  0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(3199, 1'b1, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(3200, 1'b0, 0,   1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(3204, 1'b0, 1,   1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(6399, 1'b1, 799, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(6400, 1'b0, 0,   2, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[10] = mk(6976, 1'b0, 144, 2, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            while (n < tbl[i].n) @(negedge clk);
            #2;
            check_obs($sformatf("table[%0d]", i), get_a(), tbl[i].exp);
        end

        // Frame wrap on the small raster: both ticks together for one clk.
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (vga_b.frame_tick) found = 1'b1;
        end
        check_val("frame_tick_seen", 32'(found), 32'd1);
        if (found) begin
            check_val("wrap_line_tick", 32'(vga_b.line_tick), 32'd1);
            check_val("wrap_hcount", 32'(vga_b.hCount), 32'd0);
            check_val("wrap_vcount", 32'(vga_b.vCount), 32'd0);
            @(negedge clk);
            check_val("wrap_ft_width", 32'(vga_b.frame_tick), 32'd0);
            check_val("wrap_lt_width", 32'(vga_b.line_tick), 32'd0);
        end

        // Asynchronous reset mid-line, between clock edges.
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(negedge clk);
            if (vga_a.hCount == 10'd400) found = 1'b1;
        end
        check_val("reach_h400", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_obs("async_rst_default", get_a(), '0);
        check_obs("async_rst_small", get_b(), '0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Three small-raster frames after release.
        while (n < 1200) @(negedge clk);
        #2;
        check_val("fc_after_3_frames", 32'(vga_b.frame_count),
`ifdef VGA_FRAME_COUNT_EN
                  32'd3
`else
                  32'd0
`endif
        );
        check_val("fc_frame_tick", 32'(vga_b.frame_tick), 32'd1);
        check_val("fc_default_zero", 32'(vga_a.frame_count), 32'd0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
